// File: rtl/horizontal_tf_gen.sv
// Twiddle-factor generator: CH channels of tf_k = seed * step^k mod N through a MUL_LAT-deep multiplier.
// Optional macro HTF_CEN_EN: CEN=1 freezes FSM, counters and multiplier pipeline.
module horizontal_tf_gen #(
    parameter int P_WIDTH   = 64,
    parameter int CH        = 4,
    parameter int GROUP_LEN = 16,
    parameter int MUL_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          CEN,
    input  logic                          start,
    input  logic [CH*P_WIDTH-1:0]         seed_in,
    input  logic [CH*P_WIDTH-1:0]         step_in,
    input  logic [P_WIDTH-1:0]            N_in,
    output logic [CH*P_WIDTH-1:0]         tf_out,
    output logic                          tf_valid,
    output logic [$clog2(GROUP_LEN)-1:0]  tf_idx,
    output logic                          busy,
    output logic                          done
);
    localparam int IW = $clog2(GROUP_LEN);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;
    state_t state_q, state_d;

    logic [P_WIDTH-1:0] step_q [CH];
    logic [P_WIDTH-1:0] n_q;
    logic [P_WIDTH-1:0] pipe_q [MUL_LAT][CH];
    logic [CW-1:0]      cnt_q;
    logic [P_WIDTH-1:0] next_tf    [CH];
    logic [P_WIDTH-1:0] launch_res [CH];
    logic run, accept, load, last;

    function automatic logic [P_WIDTH-1:0] mulmod(input logic [P_WIDTH-1:0] a,
                                                   input logic [P_WIDTH-1:0] b,
                                                   input logic [P_WIDTH-1:0] n);
        logic [2*P_WIDTH-1:0] prod;
        prod = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
        if (n == '0)
            return '0;
        return P_WIDTH'(prod % {{P_WIDTH{1'b0}}, n});
    endfunction

`ifdef HTF_CEN_EN
    assign run = ~CEN;
`else
    assign run = 1'b1;
`endif

    // done cycle still counts as busy, so a start then is ignored
    assign accept = run && (state_q == IDLE) && start && !CEN && !done;
    assign last   = (state_q != IDLE) && (tf_idx == IW'(GROUP_LEN - 2));
    assign busy   = (state_q != IDLE) || done;

    always_comb begin
        load = accept;
        if (run) begin
            if (state_q == EMIT)
                load = 1'b1;
            else if (state_q == WAIT && cnt_q == CW'(MUL_LAT - 1))
                load = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            next_tf[c]    = accept ? seed_in[c*P_WIDTH +: P_WIDTH] : pipe_q[MUL_LAT-1][c];
            launch_res[c] = accept ? mulmod(next_tf[c], step_in[c*P_WIDTH +: P_WIDTH], N_in)
                                   : mulmod(next_tf[c], step_q[c], n_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = (MUL_LAT == 1) ? EMIT : WAIT;
            EMIT, WAIT: if (load && last) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tf_out   <= '0;
            tf_valid <= 1'b0;
            tf_idx   <= '0;
            done     <= 1'b0;
            cnt_q    <= '0;
            n_q      <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                step_q[c] <= '0;
                for (int unsigned s = 0; s < MUL_LAT; s++)
                    pipe_q[s][c] <= '0;
            end
        end else if (!run) begin
            tf_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                n_q <= N_in;
                for (int unsigned c = 0; c < CH; c++)
                    step_q[c] <= step_in[c*P_WIDTH +: P_WIDTH];
            end
            // pipeline shifts every running cycle; only the counted slot is consumed
            for (int unsigned c = 0; c < CH; c++) begin
                pipe_q[0][c] <= launch_res[c];
                for (int unsigned s = 1; s < MUL_LAT; s++)
                    pipe_q[s][c] <= pipe_q[s-1][c];
            end
            if (load) begin
                for (int unsigned c = 0; c < CH; c++)
                    tf_out[c*P_WIDTH +: P_WIDTH] <= next_tf[c];
                tf_valid <= 1'b1;
                tf_idx   <= accept ? '0 : IW'(tf_idx + 1'b1);
                done     <= last;
                cnt_q    <= '0;
            end else begin
                tf_valid <= 1'b0;
                done     <= 1'b0;
                if (state_q == WAIT)
                    cnt_q <= CW'(cnt_q + 1'b1);
            end
        end
    end
endmodule

// File: tb/tb_horizontal_tf_gen.sv
// Directed bench for horizontal_tf_gen: one MUL_LAT=2 instance and one MUL_LAT=1 instance.
module tb_horizontal_tf_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CEN = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] seed_in = '0, step_in = '0;
    logic [15:0] N_in = '0;
    logic [31:0] tf_out_a, tf_out_b;
    logic        tf_valid_a, tf_valid_b, busy_a, busy_b, done_a, done_b;
    logic [1:0]  tf_idx_a;
    logic [3:0]  tf_idx_b;

    int n_checks = 0, n_errors = 0;
    int poke_kind = 0, poke_at = 0;
    int vcyc[$], v0[$], v1[$], vidx[$];
    int exp_cyc[$], exp0[$], exp1[$];
    int ndone, done_cyc, busy_low;

    always #5 clk = ~clk;

    horizontal_tf_gen #(.P_WIDTH(16), .CH(2), .GROUP_LEN(4), .MUL_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .start(start_a), .seed_in(seed_in),
        .step_in(step_in), .N_in(N_in), .tf_out(tf_out_a), .tf_valid(tf_valid_a),
        .tf_idx(tf_idx_a), .busy(busy_a), .done(done_a));

    horizontal_tf_gen #(.P_WIDTH(16), .CH(2), .GROUP_LEN(16), .MUL_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .start(start_b), .seed_in(seed_in),
        .step_in(step_in), .N_in(N_in), .tf_out(tf_out_b), .tf_valid(tf_valid_b),
        .tf_idx(tf_idx_b), .busy(busy_b), .done(done_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_group(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic capture(input int sel, input int budget);
        logic [31:0] o;
        logic v, d, b;
        int ix;
        vcyc.delete(); v0.delete(); v1.delete(); vidx.delete();
        ndone = 0; done_cyc = 0; busy_low = 0;
        for (int i = 1; i <= budget; i++) begin
            start_a = (poke_kind == 1 && i == poke_at);
            if (poke_kind == 2 && i == poke_at) rst_n = 1'b0;
            if (poke_kind == 2 && i == poke_at + 1) rst_n = 1'b1;
            CEN = (poke_kind == 3 && i >= poke_at && i < poke_at + 3);
            #1;
            if (sel == 0) begin
                o = tf_out_a; v = tf_valid_a; d = done_a; b = busy_a; ix = int'(tf_idx_a);
            end else begin
                o = tf_out_b; v = tf_valid_b; d = done_b; b = busy_b; ix = int'(tf_idx_b);
            end
            if (poke_kind == 2 && i == poke_at) begin
                check("rst_mid.tf_out", o, 0);
                check("rst_mid.valid", v, 0);
                check("rst_mid.busy", b, 0);
                check("rst_mid.done", d, 0);
                check("rst_mid.idx", ix, 0);
            end
            if (v) begin
                vcyc.push_back(i); v0.push_back(int'(o[15:0]));
                v1.push_back(int'(o[31:16])); vidx.push_back(ix);
            end
            if (d) begin ndone++; done_cyc = i; end
            if (!b && busy_low == 0) busy_low = i;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        CEN = 1'b0;
        poke_kind = 0;
    endtask

    task automatic verify(input string name, input int exp_done, input int exp_busy_low);
        check({name, ".nvec"}, vcyc.size(), exp_cyc.size());
        for (int k = 0; k < exp_cyc.size(); k++) begin
            check($sformatf("%s.cyc%0d", name, k), (k < vcyc.size()) ? vcyc[k] : -1, exp_cyc[k]);
            check($sformatf("%s.ch0_%0d", name, k), (k < v0.size()) ? v0[k] : -1, exp0[k]);
            check($sformatf("%s.ch1_%0d", name, k), (k < v1.size()) ? v1[k] : -1, exp1[k]);
            check($sformatf("%s.idx%0d", name, k), (k < vidx.size()) ? vidx[k] : -1, k);
        end
        check({name, ".ndone"}, ndone, (exp_done > 0) ? 1 : 0);
        check({name, ".done_cyc"}, done_cyc, exp_done);
        check({name, ".busy_low"}, busy_low, exp_busy_low);
    endtask

    task automatic setup_basic();
        seed_in = {16'd5, 16'd1};
        step_in = {16'd2, 16'd3};
        N_in    = 16'd97;
        exp_cyc = '{1, 3, 5, 7};
        exp0    = '{1, 3, 9, 27};
        exp1    = '{5, 10, 20, 40};
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.tf_out", tf_out_a, 0);
        check("rst.valid", tf_valid_a, 0);
        check("rst.idx", tf_idx_a, 0);
        check("rst.busy", busy_a, 0);
        check("rst.done", done_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        setup_basic();
        start_group(0); capture(0, 12); verify("basic", 7, 8);

        seed_in = {16'd96, 16'd50};
        step_in = {16'd96, 16'd2};
        exp0 = '{50, 3, 6, 12};
        exp1 = '{96, 1, 96, 1};
        start_group(0); capture(0, 12); verify("wrap", 7, 8);

        seed_in = {16'd9, 16'd7};
        step_in = {16'd1, 16'd5};
        N_in = 16'd0;
        exp0 = '{7, 0, 0, 0};
        exp1 = '{9, 0, 0, 0};
        start_group(0); capture(0, 12); verify("nzero", 7, 8);

        setup_basic();
        poke_kind = 1; poke_at = 4;
        start_group(0);
        seed_in = {16'd11, 16'd12};
        step_in = {16'd13, 16'd14};
        capture(0, 12); verify("start_busy", 7, 8);

        setup_basic();
        poke_kind = 2; poke_at = 4;
        start_group(0); capture(0, 12);
        exp_cyc = '{1, 3};
        exp0 = '{1, 3};
        exp1 = '{5, 10};
        verify("rst_abort", 0, 4);

        setup_basic();
        start_group(0); capture(0, 12); verify("fresh", 7, 8);

        setup_basic();
        poke_kind = 3; poke_at = 2;
        start_group(0);
`ifdef HTF_CEN_EN
        capture(0, 14);
        exp_cyc = '{1, 6, 8, 10};
        verify("cen", 10, 11);
`else
        capture(0, 14);
        verify("cen", 7, 8);
`endif

        seed_in = {16'd1, 16'd1};
        step_in = {16'd2, 16'd1};
        N_in = 16'd97;
        exp_cyc.delete(); exp0.delete();
        exp1 = '{1, 2, 4, 8, 16, 32, 64, 31, 62, 27, 54, 11, 22, 44, 88, 79};
        for (int k = 0; k < 16; k++) begin
            exp_cyc.push_back(k + 1);
            exp0.push_back(1);
        end
        start_group(1); capture(1, 20); verify("lat1", 16, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
